fpu_arbiter: RTL and testbench

//  Shares one FPU instance (32-bit float: 1 sign, 10-bit exp bias 511, 21-bit frac)

---
 rtl/fpu_arbiter.sv | 154 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin arbiter sharing one FPU between two requesters
// Sequencing: IDLE -> ISSUE -> WAIT -> RESPOND, with a WAIT watchdog against a hung FPU.
module fpu_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int OPC_W       = 2
) (
  input  logic             clock_100Khz,
  input  logic             reset,
  input  logic             req0,
  input  logic [31:0]      op0_a,
  input  logic [31:0]      op0_b,
  input  logic [OPC_W-1:0] op0_code,
  output logic             ack0,
  output logic [31:0]      res0,
  output logic             err0,
  input  logic             req1,
  input  logic [31:0]      op1_a,
  input  logic [31:0]      op1_b,
  input  logic [OPC_W-1:0] op1_code,
  output logic             ack1,
  output logic [31:0]      res1,
  output logic             err1,
  output logic             fpu_start,
  output logic [31:0]      fpu_op_a,
  output logic [31:0]      fpu_op_b,
  output logic [OPC_W-1:0] fpu_opcode,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_status,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  // Counter value on the last WAIT cycle allowed before a forced error completion.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_rr;
  logic             r_grant;
  logic [7:0]       r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [OPC_W-1:0] r_opcode;
  logic [31:0]      r_res0;
  logic [31:0]      r_res1;
  logic             r_err0;
  logic             r_err1;

  logic w_any;
  logic w_win;
  logic w_timeout;

  assign w_any     = req0 | req1;
  assign w_win     = (req0 & req1) ? r_rr : req1;
  assign w_timeout = (r_cnt == TMO_LAST);

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (fpu_done || w_timeout) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    fpu_start = 1'b0;
    busy      = 1'b1;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_ISSUE:   fpu_start = 1'b1;
      S_RESPOND: begin
        ack0 = ~r_grant;
        ack1 = r_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      r_rr     <= 1'b0;
      r_grant  <= 1'b0;
      r_cnt    <= 8'd0;
      r_op_a   <= 32'd0;
      r_op_b   <= 32'd0;
      r_opcode <= '0;
      r_res0   <= 32'd0;
      r_res1   <= 32'd0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_win;
            r_op_a   <= w_win ? op1_a : op0_a;
            r_op_b   <= w_win ? op1_b : op0_b;
            r_opcode <= w_win ? op1_code : op0_code;
          end
        end
        S_ISSUE: r_cnt <= 8'd0;
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A result arriving on the timeout edge takes priority over the forced error.
          if (fpu_done) begin
            if (r_grant) begin
              r_res1 <= fpu_result;
              r_err1 <= fpu_status;
            end else begin
              r_res0 <= fpu_result;
              r_err0 <= fpu_status;
            end
          end else if (w_timeout) begin
            if (r_grant) begin
              r_res1 <= 32'd0;
              r_err1 <= 1'b1;
            end else begin
              r_res0 <= 32'd0;
              r_err0 <= 1'b1;
            end
          end
        end
        S_RESPOND: r_rr <= ~r_grant;
        default: ;
      endcase
    end
  end

  assign res0       = r_res0;
  assign res1       = r_res1;
  assign err0       = r_err0;
  assign err1       = r_err1;
  assign fpu_op_a   = r_op_a;
  assign fpu_op_b   = r_op_b;
  assign fpu_opcode = r_opcode;
  assign grant_id   = r_grant;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a behavioural FPU and arbitration model
`timescale 1ns/1ps
module tb_fpu_arbiter;
  localparam int TMO   = 10;
  localparam int OPC_W = 2;

  logic             clock_100Khz = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       tb_req = 2'b00;
  logic [31:0]      tb_a [2];
  logic [31:0]      tb_b [2];
  logic [OPC_W-1:0] tb_c [2];
  logic             fpu_done = 1'b0;
  logic [31:0]      fpu_result = 32'd0;
  logic             fpu_status = 1'b0;

  logic             ack0, ack1, err0, err1, fpu_start, busy, grant_id;
  logic [31:0]      res0, res1, fpu_op_a, fpu_op_b;
  logic [OPC_W-1:0] fpu_opcode;

  always #5000 clock_100Khz = ~clock_100Khz;

  fpu_arbiter #(.TIMEOUT_CYC(TMO), .OPC_W(OPC_W)) dut (
    .clock_100Khz(clock_100Khz), .reset(reset),
    .req0(tb_req[0]), .op0_a(tb_a[0]), .op0_b(tb_b[0]), .op0_code(tb_c[0]),
    .ack0(ack0), .res0(res0), .err0(err0),
    .req1(tb_req[1]), .op1_a(tb_a[1]), .op1_b(tb_b[1]), .op1_code(tb_c[1]),
    .ack1(ack1), .res1(res1), .err1(err1),
    .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_opcode(fpu_opcode),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_status(fpu_status),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct { logic id; logic [31:0] res; logic err; } exp_t;
  typedef struct { int d; logic [31:0] res; logic st; } frc_t;

  exp_t        exp_q[$];
  frc_t        frc_q[$];
  logic [1:0]  req_at_edge;
  logic        prefer;
  logic        granted [2];
  logic [31:0] model_res [2];
  int          n_checks = 0;
  int          n_err = 0;
  int          n_ack = 0;
  int          n_push = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Request vector the DUT saw at the most recent rising edge.
  always @(posedge clock_100Khz) req_at_edge <= tb_req;

  // Ack monitor: pops the scoreboard and tracks round-robin preference.
  exp_t mon_e;
  logic mon_id;
  initial begin
    forever begin
      @(negedge clock_100Khz);
      if (!reset) begin
        prefer       = 1'b0;
        model_res[0] = 32'd0;
        model_res[1] = 32'd0;
      end
      if (ack0 || ack1) begin
        n_ack++;
        chk("ack_onehot", {63'd0, ack0 & ack1}, 64'd0);
        mon_id = ack1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_ack id=%0d with empty scoreboard at %0t", mon_id, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_id", {63'd0, mon_id}, {63'd0, mon_e.id});
          chk("ack_res", {32'd0, mon_id ? res1 : res0}, {32'd0, mon_e.res});
          chk("ack_err", {63'd0, mon_id ? err1 : err0}, {63'd0, mon_e.err});
          chk("other_res_hold", {32'd0, mon_id ? res0 : res1}, {32'd0, model_res[!mon_id]});
          model_res[mon_id] = mon_e.res;
        end
        prefer = !mon_id;
      end
    end
  end

  // Behavioural FPU: on each start, decide the winner from the rules, then answer after d WAIT cycles.
  logic [1:0]       rsp_pend;
  logic             rsp_w;
  logic [31:0]      rsp_ea, rsp_eb;
  logic [OPC_W-1:0] rsp_ec;
  frc_t             rsp_f;
  exp_t             rsp_e;
  task automatic responder();
    forever begin
      @(negedge clock_100Khz);
      if (fpu_start) begin
        rsp_pend = req_at_edge;
        rsp_w    = (rsp_pend == 2'b11) ? prefer : rsp_pend[1];
        chk("start_has_req", {63'd0, rsp_pend != 2'b00}, 64'd1);
        rsp_ea = tb_a[rsp_w];
        rsp_eb = tb_b[rsp_w];
        rsp_ec = tb_c[rsp_w];
        chk("fpu_op_ab", {fpu_op_a, fpu_op_b}, {rsp_ea, rsp_eb});
        chk("fpu_opcode", {62'd0, fpu_opcode}, {62'd0, rsp_ec});
        granted[rsp_w] = 1'b1;
        if (frc_q.size() != 0) begin
          rsp_f = frc_q.pop_front();
        end else begin
          rsp_f.d   = int'($urandom_range(0, TMO + 2));
          rsp_f.res = $urandom;
          rsp_f.st  = ($urandom_range(0, 3) == 0);
        end
        rsp_e.id = rsp_w;
        if (rsp_f.d >= 1 && rsp_f.d <= TMO) begin
          rsp_e.res = rsp_f.res;
          rsp_e.err = rsp_f.st;
        end else begin
          rsp_e.res = 32'd0;
          rsp_e.err = 1'b1;
        end
        exp_q.push_back(rsp_e);
        n_push++;
        if (rsp_f.d > 0) begin
          @(posedge clock_100Khz); #1;
          repeat (rsp_f.d - 1) begin
            @(posedge clock_100Khz); #1;
          end
          fpu_done   = 1'b1;
          fpu_result = rsp_f.res;
          fpu_status = rsp_f.st;
          if (rsp_f.d <= TMO + 1)
            chk("op_stable", {fpu_op_a, fpu_op_b}, {rsp_ea, rsp_eb});
          @(posedge clock_100Khz); #1;
          fpu_done   = 1'b0;
          fpu_status = 1'b0;
          fpu_result = $urandom;
        end
      end
    end
  endtask

  task automatic req_txn(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [OPC_W-1:0] c);
    bit got;
    @(posedge clock_100Khz); #1;
    tb_a[i] = a;
    tb_b[i] = b;
    tb_c[i] = c;
    tb_req[i] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clock_100Khz);
      if ((i == 0) ? ack0 : ack1) begin
        got = 1'b1;
      end else if (granted[i]) begin
        // Once captured, the requester may scramble operands or drop its request.
        tb_a[i] = $urandom;
        tb_b[i] = $urandom;
        tb_c[i] = OPC_W'($urandom);
        if ($urandom_range(0, 1) == 1) tb_req[i] = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL ack_timeout requester=%0d no ack within 400 cycles", i);
    end
    granted[i] = 1'b0;
    @(posedge clock_100Khz); #1;
    tb_req[i] = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clock_100Khz);
    $display("FAIL watchdog bench did not finish within 60000 cycles");
    $fatal(1);
  end

  bit started;
  initial begin
    for (int i = 0; i < 2; i++) begin
      tb_a[i] = 32'd0;
      tb_b[i] = 32'd0;
      tb_c[i] = '0;
      granted[i] = 1'b0;
      model_res[i] = 32'd0;
    end
    prefer = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock_100Khz);
    chk("rst_ctrl", {55'd0, ack0, ack1, err0, err1, busy, fpu_start, grant_id, fpu_opcode}, 64'd0);
    chk("rst_res", {res0, res1}, 64'd0);
    chk("rst_fpu_op", {fpu_op_a, fpu_op_b}, 64'd0);
    @(posedge clock_100Khz); #1;
    reset = 1'b1;

    // Stray done while idle must be ignored.
    fpu_done = 1'b1; fpu_result = 32'h12345678; fpu_status = 1'b1;
    @(posedge clock_100Khz); #1;
    fpu_done = 1'b0; fpu_status = 1'b0;
    @(negedge clock_100Khz);
    chk("stray_idle_ctrl", {61'd0, busy, ack0, ack1}, 64'd0);
    chk("stray_idle_res", {res0, res1}, 64'd0);

    // Single minimum-latency transaction on requester 0.
    @(posedge clock_100Khz); #1;
    tb_a[0] = 32'h3FE00000; tb_b[0] = 32'h40000000; tb_c[0] = '0; tb_req[0] = 1'b1;
    @(negedge clock_100Khz);
    chk("single_start_early", {63'd0, fpu_start}, 64'd0);
    @(negedge clock_100Khz);
    chk("single_start", {63'd0, fpu_start}, 64'd1);
    chk("single_ops", {fpu_op_a, fpu_op_b}, {32'h3FE00000, 32'h40000000});
    chk("single_grant", {62'd0, grant_id, busy}, 64'd1);
    exp_q.push_back('{1'b0, 32'h40100000, 1'b0});
    n_push++;
    @(posedge clock_100Khz); #1;
    fpu_done = 1'b1; fpu_result = 32'h40100000; fpu_status = 1'b0;
    @(negedge clock_100Khz);
    chk("single_start_pulse", {63'd0, fpu_start}, 64'd0);
    @(posedge clock_100Khz); #1;
    fpu_done = 1'b0;
    @(negedge clock_100Khz);
    chk("single_ack", {62'd0, ack0, ack1}, 64'd2);
    @(posedge clock_100Khz); #1;
    tb_req[0] = 1'b0;
    @(negedge clock_100Khz);
    chk("single_ack_pulse", {61'd0, ack0, ack1, busy}, 64'd0);
    chk("single_res_hold", {32'd0, res0}, 64'h40100000);

    // Reset asserted mid-WAIT aborts the transaction with no ack.
    @(posedge clock_100Khz); #1;
    tb_a[1] = $urandom; tb_b[1] = $urandom; tb_c[1] = 2'd3; tb_req[1] = 1'b1;
    started = 1'b0;
    for (int k = 0; k < 10 && !started; k++) begin
      @(negedge clock_100Khz);
      if (fpu_start) started = 1'b1;
    end
    chk("abort_started", {63'd0, started}, 64'd1);
    repeat (3) @(negedge clock_100Khz);
    reset = 1'b0;
    #1;
    chk("async_rst_ctrl", {55'd0, ack0, ack1, err0, err1, busy, fpu_start, grant_id, fpu_opcode}, 64'd0);
    chk("async_rst_res", {res0, res1}, 64'd0);
    chk("async_rst_op", {fpu_op_a, fpu_op_b}, 64'd0);
    tb_req[1] = 1'b0;
    repeat (2) @(posedge clock_100Khz);
    #1 reset = 1'b1;
    repeat (5) @(negedge clock_100Khz);
    chk("no_ack_after_abort", 64'(n_ack), 64'd1);

    fork
      responder();
    join_none

    // Simultaneous pairs: winner follows the round-robin rules in the model.
    for (int p = 0; p < 2; p++) begin
      fork
        req_txn(0, $urandom, $urandom, OPC_W'($urandom));
        req_txn(1, $urandom, $urandom, OPC_W'($urandom));
      join
    end

    frc_q.push_back('{0, 32'h0, 1'b0});
    req_txn(1, $urandom, $urandom, 2'd1);
    frc_q.push_back('{3, 32'h7FE00000, 1'b1});
    req_txn(0, $urandom, $urandom, 2'd2);
    frc_q.push_back('{TMO, 32'hC0A81234, 1'b0});
    req_txn(0, $urandom, $urandom, 2'd0);
    frc_q.push_back('{TMO + 1, 32'h55AA55AA, 1'b0});
    req_txn(1, $urandom, $urandom, 2'd3);
    frc_q.push_back('{TMO + 2, 32'h3C3C3C3C, 1'b0});
    req_txn(0, $urandom, $urandom, 2'd1);

    fork
      begin
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock_100Khz);
          req_txn(0, $urandom, $urandom, OPC_W'($urandom));
        end
      end
      begin
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clock_100Khz);
          req_txn(1, $urandom, $urandom, OPC_W'($urandom));
        end
      end
    join

    repeat (20) @(negedge clock_100Khz);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("ack_count", 64'(n_ack), 64'(n_push));
    chk("final_idle", {63'd0, busy}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
